ece178_key_pio_in: RTL and testbench
====================================

Name: ece178_key_pio_in

Overview:
- Avalon-MM slave input port: the read-side counterpart of the HEX output PIOs.
- Samples external pins (KEY/SW) and passes them through a 2-flop synchronizer and per-bit debounce.
- Provides a readable data register, per-bit edge capture and an interrupt mask.
- Drives a level IRQ to the Nios II.

Parameters:
- DATA_WIDTH, 4, number of input pins (1..32).
- DEBOUNCE_CYCLES, 50000, consecutive stable clocks required before a debounced bit changes (1 ms at 50 MHz). Minimum 1.
- EDGE_TYPE, 0, edge type that sets capture bits: 0 = falling, 1 = rising, 2 = any.
- IDLE_LEVEL, all ones (DATA_WIDTH bits), reset value of the synchronizer and debounced registers (keys idle high).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  2  word address: 0 data, 1 reserved, 2 irq mask, 3 edge capture
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  DATA_WIDTH  asynchronous external pins
- readdata  out  32  read data, combinational from address (0 wait states, 0 read latency)
- irq  out  1  level interrupt, registered

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, reset). All state updates on posedge clk only.
- Reset values:
  - sync1, sync2 = IDLE_LEVEL.
  - debounced = IDLE_LEVEL.
  - Debounce counters = 0.
  - irq_mask = 0, edge_capture = 0, irq = 0.
  - readdata follows address; it reads 0 at address 0 only if IDLE_LEVEL = 0.
- Synchronizer:
  - sync1 <= in_port; sync2 <= sync1.
  - A pin change reaches sync2 two clocks later.
- Debounce, per bit i:
  - Counter width = clog2(DEBOUNCE_CYCLES+1).
  - If sync2[i] == debounced[i]: cnt[i] <= 0.
  - Otherwise cnt[i] increments. When cnt[i] == DEBOUNCE_CYCLES-1 and the bit still differs: debounced[i] <= sync2[i] and cnt[i] <= 0.
  - Result: debounced changes exactly DEBOUNCE_CYCLES clocks after sync2 first differs and stays different.
  - A glitch shorter than DEBOUNCE_CYCLES resets the counter and leaves no change.
- Edge detect:
  - prev <= debounced; prev resets to IDLE_LEVEL.
  - fall = prev & ~debounced; rise = ~prev & debounced.
  - edge is selected from fall/rise/either according to EDGE_TYPE.
- Edge capture:
  - edge_capture[i] sets on edge[i] and is sticky.
  - Write to address 3 clears each bit where writedata[i] = 1 (write-1-to-clear).
  - Set and clear of the same bit in the same cycle: set wins (bit = 1).
- IRQ mask:
  - Write to address 2 loads writedata[DATA_WIDTH-1:0] into irq_mask.
- IRQ:
  - irq <= |(edge_capture & irq_mask), registered.
  - irq asserts 1 clock after capture; it clears 1 clock after the clear write, or 1 clock after the mask write if masking.
- Register access:
  - Writes take effect only when chipselect && !write_n.
  - Writes to address 0 and 1 are ignored.
  - Read mux: address 0 = debounced, 2 = irq_mask, 3 = edge_capture, 1 = 0. Upper bits above DATA_WIDTH read 0.
  - Reads have no side effects.
- Reset mid-operation:
  - A reset during a debounce count or with pending captures discards all of it.
  - Because prev = debounced = IDLE_LEVEL after reset, no edge is generated by reset itself.
- Counters saturate only by the compare rule above; there is no wrap-around path.

Test Plan:
1. Reset, DEBOUNCE_CYCLES = 4, in_port = 4'hF held: read addr 0 -> 0x0000000F; addr 2 and addr 3 -> 0; irq = 0 for 20 cycles.
2. in_port[0] to 0 and held:
   - debounced[0] falls exactly 2+4 clocks after the pin change, and addr 0 reads 0xE from that cycle.
   - edge_capture = 0x1 one clock after debounced[0] falls.
   - irq stays 0 (mask = 0).
3. in_port[1] pulses low for 3 cycles, then returns high: addr 0 stays 0xF; edge_capture unchanged; no counter leak on a repeat pulse of 3.
4. Write addr 2 = 0x1 with edge_capture[0] = 1:
   - irq = 1 one clock after the write.
   - Write addr 3 = 0x1: edge_capture = 0, irq = 0 one clock later.
5. Write addr 3 = 0x2 in the same cycle that a debounced falling edge on bit 1 occurs: edge_capture[1] = 1 (set wins).
6. Assert reset for 1 cycle while bit 2 is mid-debounce (cnt = 2) with edge_capture = 0x3 and mask = 0xF:
   - After reset, all registers are 0 and debounced = 0xF.
   - irq = 0.
   - Bit 2 needs the full 4 stable cycles after the sync latency to change.

Source files
------------

// File: rtl/ece178_key_pio_in_if.sv
// Avalon-MM slave bus bundle for the key/switch input PIO.
interface ece178_key_pio_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/ece178_key_pio_in.sv
// Avalon-MM input PIO: synchronized, debounced pins with sticky edge capture,
// interrupt mask and a registered level IRQ.
module ece178_key_pio_in #(
  parameter int unsigned            DATA_WIDTH      = 4,
  parameter int unsigned            DEBOUNCE_CYCLES = 50000,
  parameter int unsigned            EDGE_TYPE       = 0,
  parameter logic [DATA_WIDTH-1:0]  IDLE_LEVEL      = '1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_port,
  ece178_key_pio_in_if.slave    bus
);

  localparam int unsigned      CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]       ADDR_DATA    = 2'd0;
  localparam logic [1:0]       ADDR_MASK    = 2'd2;
  localparam logic [1:0]       ADDR_CAPTURE = 2'd3;

  logic [DATA_WIDTH-1:0] sync1;
  logic [DATA_WIDTH-1:0] sync2;
  logic [DATA_WIDTH-1:0] debounced;
  logic [DATA_WIDTH-1:0] prev;
  logic [DATA_WIDTH-1:0] irq_mask;
  logic [DATA_WIDTH-1:0] edge_capture;
  logic [CNT_W-1:0]      cnt [DATA_WIDTH];

  logic [DATA_WIDTH-1:0] fall;
  logic [DATA_WIDTH-1:0] rise;
  logic [DATA_WIDTH-1:0] edge_hit;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] clr_mask;
  logic                  wr_en;

  assign wr_en    = bus.chipselect && !bus.write_n;
  assign wdata    = bus.writedata[DATA_WIDTH-1:0];
  assign clr_mask = (wr_en && (bus.address == ADDR_CAPTURE)) ? wdata : '0;

  generate
    if (DATA_WIDTH < 32) begin : g_unused_wdata
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^bus.writedata[31:DATA_WIDTH];
    end
  endgenerate

  // Two-flop synchronizer; idles at the released-key level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= IDLE_LEVEL;
      sync2 <= IDLE_LEVEL;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: a bit follows sync2 only after DEBOUNCE_CYCLES differing clocks
  always_ff @(posedge clk) begin
    if (reset) begin
      debounced <= IDLE_LEVEL;
      for (int i = 0; i < int'(DATA_WIDTH); i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DATA_WIDTH); i++) begin
        if (sync2[i] == debounced[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          debounced[i] <= sync2[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    fall = prev & ~debounced;
    rise = ~prev & debounced;
    if (EDGE_TYPE == 0)      edge_hit = fall;
    else if (EDGE_TYPE == 1) edge_hit = rise;
    else                     edge_hit = fall | rise;
  end

  // Capture is set-dominant over a simultaneous write-1-to-clear
  always_ff @(posedge clk) begin
    if (reset) begin
      prev         <= IDLE_LEVEL;
      irq_mask     <= '0;
      edge_capture <= '0;
      bus.irq      <= 1'b0;
    end else begin
      prev         <= debounced;
      edge_capture <= (edge_capture & ~clr_mask) | edge_hit;
      bus.irq      <= |(edge_capture & irq_mask);
      if (wr_en && (bus.address == ADDR_MASK)) irq_mask <= wdata;
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:    bus.readdata = 32'(debounced);
      ADDR_MASK:    bus.readdata = 32'(irq_mask);
      ADDR_CAPTURE: bus.readdata = 32'(edge_capture);
      default:      bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_ece178_key_pio_in.sv
// Randomized scoreboard bench for ece178_key_pio_in against a history-based reference model.
module tb_ece178_key_pio_in;

  localparam int unsigned DW = 4;
  localparam int unsigned DC = 4;

  typedef struct packed {
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  logic          clk;
  logic          reset;
  logic [DW-1:0] in_port;

  ece178_key_pio_in_if bus_if ();

  ece178_key_pio_in #(
    .DATA_WIDTH      (DW),
    .DEBOUNCE_CYCLES (DC),
    .EDGE_TYPE       (0),
    .IDLE_LEVEL      (4'hF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exp_q[$];

  // Reference model: debounced bit flips once the last DC synchronized samples all disagree with it
  logic [DW-1:0] m_sync1, m_sync2, m_deb, m_prev, m_cap, m_mask;
  logic          m_irq;
  logic [DW-1:0] m_hist[$];

  function automatic void model_reset();
    m_sync1 = '1; m_sync2 = '1; m_deb = '1; m_prev = '1;
    m_cap = '0; m_mask = '0; m_irq = 1'b0;
    m_hist.delete();
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    if (a == 2'd0) r[DW-1:0] = m_deb;
    if (a == 2'd2) r[DW-1:0] = m_mask;
    if (a == 2'd3) r[DW-1:0] = m_cap;
    return r;
  endfunction

  function automatic void model_step(input logic [DW-1:0] pins, input logic rst_i,
                                     input logic wr, input logic [1:0] a, input logic [31:0] wd);
    logic [DW-1:0] falls;
    logic [DW-1:0] clr;
    logic [DW-1:0] deb_old;
    bit            all_diff;
    if (rst_i) begin
      model_reset();
      return;
    end
    falls   = m_prev & ~m_deb;
    clr     = (wr && a == 2'd3) ? wd[DW-1:0] : '0;
    m_irq   = |(m_cap & m_mask);
    m_cap   = (m_cap & ~clr) | falls;
    if (wr && a == 2'd2) m_mask = wd[DW-1:0];
    deb_old = m_deb;
    m_hist.push_back(m_sync2);
    if (m_hist.size() > DC) void'(m_hist.pop_front());
    if (m_hist.size() == DC) begin
      for (int b = 0; b < int'(DW); b++) begin
        all_diff = 1'b1;
        foreach (m_hist[k]) if (m_hist[k][b] == deb_old[b]) all_diff = 1'b0;
        if (all_diff) m_deb[b] = ~deb_old[b];
      end
    end
    m_prev  = deb_old;
    m_sync2 = m_sync1;
    m_sync1 = pins;
  endfunction

  // One bus cycle: drive at negedge, queue the expected response, advance the model at posedge
  task automatic cycle(input logic [DW-1:0] pins, input logic rst_i, input logic cs,
                       input logic wn, input logic [1:0] a, input logic [31:0] wd);
    exp_t e;
    @(negedge clk);
    in_port           = pins;
    reset             = rst_i;
    bus_if.chipselect = cs;
    bus_if.write_n    = wn;
    bus_if.address    = a;
    bus_if.writedata  = wd;
    e.rd  = model_read(a);
    e.irq = m_irq;
    exp_q.push_back(e);
    @(posedge clk);
    model_step(pins, rst_i, cs && !wn, a, wd);
    cyc++;
  endtask

  task automatic idle(input logic [DW-1:0] pins, input int n);
    for (int k = 0; k < n; k++)
      cycle(pins, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3)), $urandom);
  endtask

  task automatic wr(input logic [DW-1:0] pins, input logic [1:0] a, input logic [31:0] d);
    cycle(pins, 1'b0, 1'b1, 1'b0, a, d);
  endtask

  // Monitor: compares every presented output against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus_if.readdata !== e.rd) begin
          errors++;
          $display("FAIL readdata cyc=%0d addr=%0d actual=%h required=%h",
                   cyc, bus_if.address, bus_if.readdata, e.rd);
        end
        checks++;
        if (bus_if.irq !== e.irq) begin
          errors++;
          $display("FAIL irq cyc=%0d actual=%b required=%b", cyc, bus_if.irq, e.irq);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] pins;
    int            hold;
    reset             = 1'b1;
    in_port           = 4'hF;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.address    = 2'd0;
    bus_if.writedata  = '0;
    model_reset();
    repeat (2) @(posedge clk);

    cycle(4'hF, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0);
    idle(4'hF, 20);

    idle(4'hE, 12);

    for (int r = 0; r < 2; r++) begin
      idle(4'hC, 3);
      idle(4'hE, 1);
    end
    idle(4'hE, 8);

    wr(4'hE, 2'd2, 32'h1);
    idle(4'hE, 3);
    wr(4'hE, 2'd3, 32'h1);
    idle(4'hE, 3);

    idle(4'hC, 6);
    wr(4'hC, 2'd3, 32'h2);
    idle(4'hC, 4);

    wr(4'hC, 2'd2, 32'hF);
    idle(4'hD, 8);
    idle(4'hC, 8);
    idle(4'h8, 4);
    cycle(4'h8, 1'b1, 1'b0, 1'b1, 2'd3, 32'h0);
    idle(4'h8, 12);

    pins = 4'h8;
    for (int k = 0; k < 800; k++) begin
      if (hold == 0) begin
        pins = pins ^ 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 8);
      end
      hold--;
      if ($urandom_range(0, 299) == 0)
        cycle(pins, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0);
      else
        cycle(pins, 1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
              2'($urandom_range(0, 3)), $urandom);
    end

    @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
